// File: rtl/mem_arb_pkg.sv
// Shared types and width constants for the two-requester memory bus arbiter.
package mem_arb_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
endpackage

// File: rtl/mem_arb_wdog.sv
// Stall watchdog: counts BUSY cycles without mem_ready and fires at MAX_WAIT.
module mem_arb_wdog #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_busy,
  input  logic i_mem_ready,
  output logic o_fire
);
  logic [7:0] r_cnt;

  // Held at zero outside BUSY so every transfer starts counting from 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (!i_busy) begin
      r_cnt <= '0;
    end else if (!i_mem_ready && (r_cnt != 8'hff)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_fire = i_busy && !i_mem_ready && (r_cnt == 8'(MAX_WAIT));
endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one picorv32 native memory port between two requesters.
// Optional stall watchdog enabled by defining MEM_BUS_ARBITER_WDOG_EN.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          MAX_WAIT      = 16,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hdead_beef
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_mem_valid,
  input  logic              m0_mem_instr,
  input  logic [ADDR_W-1:0] m0_mem_addr,
  input  logic [DATA_W-1:0] m0_mem_wdata,
  input  logic [STRB_W-1:0] m0_mem_wstrb,
  output logic              m0_mem_ready,
  output logic [DATA_W-1:0] m0_mem_rdata,
  input  logic              m1_mem_valid,
  input  logic              m1_mem_instr,
  input  logic [ADDR_W-1:0] m1_mem_addr,
  input  logic [DATA_W-1:0] m1_mem_wdata,
  input  logic [STRB_W-1:0] m1_mem_wstrb,
  output logic              m1_mem_ready,
  output logic [DATA_W-1:0] m1_mem_rdata,
  output logic              mem_valid,
  output logic              mem_instr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_id,
  output logic              busy,
  output logic              timeout_err
);
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("mem_bus_arbiter: MAX_WAIT must be in 1..255");
  end

  state_e r_state, w_state_nxt;
  logic   r_owner, w_owner_nxt;
  logic   r_last_owner, w_last_nxt;
  logic   w_busy, w_owner_valid, w_fire, w_done;
  logic [DATA_W-1:0] w_rdata;

  assign w_busy        = (r_state == BUSY);
  assign w_owner_valid = (r_owner == OWNER_M1) ? m1_mem_valid : m0_mem_valid;

`ifdef MEM_BUS_ARBITER_WDOG_EN
  logic w_fire_raw;
  logic r_timeout_err;

  mem_arb_wdog #(.MAX_WAIT(MAX_WAIT)) u_wdog (
    .clk         (clk),
    .resetn      (resetn),
    .i_busy      (w_busy),
    .i_mem_ready (mem_ready),
    .o_fire      (w_fire_raw)
  );

  // An abandoned transfer simply returns to IDLE; it is not a timeout.
  assign w_fire = w_fire_raw && w_owner_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_timeout_err <= 1'b0;
    end else if (w_fire) begin
      r_timeout_err <= 1'b1;
    end
  end
  assign timeout_err = r_timeout_err;
`else
  assign w_fire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign w_done = w_busy && w_owner_valid && (mem_ready || w_fire);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_owner      <= OWNER_M0;
      r_last_owner <= OWNER_M1;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    case (r_state)
      IDLE: begin
        if (m0_mem_valid || m1_mem_valid) begin
          w_state_nxt = BUSY;
          if (m0_mem_valid && m1_mem_valid) begin
            w_owner_nxt = ~r_last_owner;
          end else begin
            w_owner_nxt = m1_mem_valid ? OWNER_M1 : OWNER_M0;
          end
        end
      end
      BUSY: begin
        if (!w_owner_valid || w_done) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_owner;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mem_valid = w_busy && w_owner_valid && !w_fire;
  assign mem_instr = (r_owner == OWNER_M1) ? m1_mem_instr : m0_mem_instr;
  assign mem_addr  = (r_owner == OWNER_M1) ? m1_mem_addr  : m0_mem_addr;
  assign mem_wdata = (r_owner == OWNER_M1) ? m1_mem_wdata : m0_mem_wdata;
  assign mem_wstrb = (r_owner == OWNER_M1) ? m1_mem_wstrb : m0_mem_wstrb;

  assign w_rdata      = w_fire ? TIMEOUT_RDATA : mem_rdata;
  assign m0_mem_ready = w_done && (r_owner == OWNER_M0);
  assign m1_mem_ready = w_done && (r_owner == OWNER_M1);
  assign m0_mem_rdata = w_rdata;
  assign m1_mem_rdata = w_rdata;

  assign grant_id = r_owner;
  assign busy     = w_busy;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, corner sequences, random vs. reference model.
module tb_mem_bus_arbiter;
  localparam int TB_MAX_WAIT = 4;
`ifdef MEM_BUS_ARBITER_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  logic m0_mem_valid, m0_mem_instr, m0_mem_ready;
  logic [31:0] m0_mem_addr, m0_mem_wdata, m0_mem_rdata;
  logic [3:0]  m0_mem_wstrb;
  logic m1_mem_valid, m1_mem_instr, m1_mem_ready;
  logic [31:0] m1_mem_addr, m1_mem_wdata, m1_mem_rdata;
  logic [3:0]  m1_mem_wstrb;
  logic mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic grant_id, busy, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_WAIT(TB_MAX_WAIT), .TIMEOUT_RDATA(32'hdead_beef)) dut (
    .clk(clk), .resetn(resetn),
    .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr), .m0_mem_addr(m0_mem_addr),
    .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb), .m0_mem_ready(m0_mem_ready),
    .m0_mem_rdata(m0_mem_rdata),
    .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr), .m1_mem_addr(m1_mem_addr),
    .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb), .m1_mem_ready(m1_mem_ready),
    .m1_mem_rdata(m1_mem_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic v0, v1, mr;
    logic emv, er0, er1, egid, ebusy;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic v0, logic v1, logic mr, logic emv, logic er0, logic er1,
                              logic egid, logic ebusy, logic [31:0] eaddr);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.mr = mr; v.emv = emv; v.er0 = er0; v.er1 = er1;
    v.egid = egid; v.ebusy = ebusy; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic set_default_fields();
    m0_mem_instr = 1'b1; m0_mem_addr = 32'h100; m0_mem_wdata = 32'h0;    m0_mem_wstrb = 4'h0;
    m1_mem_instr = 1'b0; m1_mem_addr = 32'h200; m1_mem_wdata = 32'h5555; m1_mem_wstrb = 4'hf;
    mem_rdata = 32'h1234_5678;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    m0_mem_valid = 1'b0; m1_mem_valid = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Reference model state: transfer-level view of the arbiter.
  bit          mbusy, mown, mlast, merr;
  int          mcnt;
  bit          pend[2];
  logic        rinstr[2];
  logic [31:0] raddr[2], rwdata[2];
  logic [3:0]  rwstrb[2];

  initial begin
    resetn = 1'b0;
    m0_mem_valid = 1'b0; m1_mem_valid = 1'b0; mem_ready = 1'b0;
    set_default_fields();
    #12;
    chk("reset_mem_valid", mem_valid, 1'b0);
    chk("reset_m0_ready", m0_mem_ready, 1'b0);
    chk("reset_m1_ready", m1_mem_ready, 1'b0);
    chk("reset_grant", grant_id, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_terr", timeout_err, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    // Arbitration table: tie-break after reset, alternation, waits, idle ready, owner drop.
    tbl[0]  = mk(1,1,1, 0,0,0, 0,0, 32'h0);
    tbl[1]  = mk(1,1,1, 1,1,0, 0,1, 32'h100);
    tbl[2]  = mk(1,1,1, 0,0,0, 0,0, 32'h0);
    tbl[3]  = mk(1,1,1, 1,0,1, 1,1, 32'h200);
    tbl[4]  = mk(1,1,1, 0,0,0, 1,0, 32'h0);
    tbl[5]  = mk(1,1,1, 1,1,0, 0,1, 32'h100);
    tbl[6]  = mk(1,1,1, 0,0,0, 0,0, 32'h0);
    tbl[7]  = mk(1,1,1, 1,0,1, 1,1, 32'h200);
    tbl[8]  = mk(1,0,0, 0,0,0, 1,0, 32'h0);
    tbl[9]  = mk(1,0,0, 1,0,0, 0,1, 32'h100);
    tbl[10] = mk(1,0,1, 1,1,0, 0,1, 32'h100);
    tbl[11] = mk(0,0,1, 0,0,0, 0,0, 32'h0);
    tbl[12] = mk(1,0,0, 0,0,0, 0,0, 32'h0);
    tbl[13] = mk(0,1,1, 0,0,0, 0,1, 32'h0);
    tbl[14] = mk(0,1,0, 0,0,0, 0,0, 32'h0);
    tbl[15] = mk(0,1,1, 1,0,1, 1,1, 32'h200);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      m0_mem_valid = tbl[i].v0; m1_mem_valid = tbl[i].v1; mem_ready = tbl[i].mr;
      #2;
      chk($sformatf("tbl%0d_mem_valid", i), mem_valid, tbl[i].emv);
      chk($sformatf("tbl%0d_m0_ready", i), m0_mem_ready, tbl[i].er0);
      chk($sformatf("tbl%0d_m1_ready", i), m1_mem_ready, tbl[i].er1);
      chk($sformatf("tbl%0d_grant", i), grant_id, tbl[i].egid);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].ebusy);
      if (tbl[i].emv) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].eaddr);
      if (tbl[i].er0) chk($sformatf("tbl%0d_m0_rdata", i), m0_mem_rdata, 32'h1234_5678);
      if (tbl[i].er1) chk($sformatf("tbl%0d_m1_rdata", i), m1_mem_rdata, 32'h1234_5678);
    end

    // m1 write with three wait states.
    @(negedge clk);
    m0_mem_valid = 1'b0; m1_mem_valid = 1'b1; mem_ready = 1'b0;
    m1_mem_addr = 32'h40; m1_mem_wdata = 32'hAABB_CCDD; m1_mem_wstrb = 4'b0011; m1_mem_instr = 1'b0;
    #2 chk("wr_arb_busy", busy, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      mem_ready = (c == 4);
      #2;
      chk($sformatf("wr%0d_mem_valid", c), mem_valid, 1'b1);
      chk($sformatf("wr%0d_addr", c), mem_addr, 32'h40);
      chk($sformatf("wr%0d_wdata", c), mem_wdata, 32'hAABB_CCDD);
      chk($sformatf("wr%0d_wstrb", c), mem_wstrb, 4'b0011);
      chk($sformatf("wr%0d_m1_ready", c), m1_mem_ready, (c == 4));
    end
    @(negedge clk);
    m1_mem_valid = 1'b0; mem_ready = 1'b0;
    #2 chk("wr_busy_after", busy, 1'b0);

    // Asynchronous reset in the middle of a transfer.
    set_default_fields();
    @(negedge clk);
    m1_mem_valid = 1'b1;
    @(negedge clk);
    #2;
    chk("ar_busy_before", busy, 1'b1);
    chk("ar_grant_before", grant_id, 1'b1);
    resetn = 1'b0; mem_ready = 1'b1;
    #1;
    chk("ar_mem_valid", mem_valid, 1'b0);
    chk("ar_m1_ready", m1_mem_ready, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_grant", grant_id, 1'b0);
    @(negedge clk);
    resetn = 1'b1; m0_mem_valid = 1'b1; m1_mem_valid = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    #2;
    chk("ar_tie_busy", busy, 1'b1);
    chk("ar_tie_grant", grant_id, 1'b0);
    chk("ar_tie_addr", mem_addr, 32'h100);

`ifdef MEM_BUS_ARBITER_WDOG_EN
    // Memory never readies: m0 is aborted by the watchdog, then m1 completes normally.
    do_reset();
    @(negedge clk);
    m0_mem_valid = 1'b1; mem_ready = 1'b0;
    for (int c = 1; c <= TB_MAX_WAIT; c++) begin
      @(negedge clk);
      #2;
      chk($sformatf("wd%0d_mem_valid", c), mem_valid, 1'b1);
      chk($sformatf("wd%0d_m0_ready", c), m0_mem_ready, 1'b0);
      chk($sformatf("wd%0d_terr", c), timeout_err, 1'b0);
    end
    @(negedge clk);
    #2;
    chk("wd_fire_m0_ready", m0_mem_ready, 1'b1);
    chk("wd_fire_rdata", m0_mem_rdata, 32'hdead_beef);
    chk("wd_fire_mem_valid", mem_valid, 1'b0);
    @(negedge clk);
    m0_mem_valid = 1'b0; m1_mem_valid = 1'b1;
    #2 chk("wd_terr_sticky", timeout_err, 1'b1);
    @(negedge clk);
    mem_ready = 1'b1;
    #2;
    chk("wd_m1_ready", m1_mem_ready, 1'b1);
    chk("wd_m1_rdata", m1_mem_rdata, 32'h1234_5678);
    chk("wd_terr_still", timeout_err, 1'b1);
`endif

    // Randomized traffic against the transfer-level reference model.
    do_reset();
    mbusy = 0; mown = 0; mlast = 1; merr = 0; mcnt = 0;
    pend[0] = 0; pend[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit ov, fire, done, emv;
      logic [31:0] erd;
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          pend[r]   = 1;
          raddr[r]  = $urandom;
          rwdata[r] = $urandom;
          rwstrb[r] = 4'($urandom_range(0, 15));
          rinstr[r] = 1'($urandom_range(0, 1));
        end else if (pend[r] && $urandom_range(0, 31) == 0) begin
          pend[r] = 0;
        end
      end
      m0_mem_valid = pend[0]; m0_mem_addr = raddr[0]; m0_mem_wdata = rwdata[0];
      m0_mem_wstrb = rwstrb[0]; m0_mem_instr = rinstr[0];
      m1_mem_valid = pend[1]; m1_mem_addr = raddr[1]; m1_mem_wdata = rwdata[1];
      m1_mem_wstrb = rwstrb[1]; m1_mem_instr = rinstr[1];
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      #2;
      ov   = mbusy && pend[mown];
      fire = WDOG && ov && !mem_ready && (mcnt == TB_MAX_WAIT);
      emv  = ov && !fire;
      done = ov && (mem_ready || fire);
      erd  = fire ? 32'hdead_beef : mem_rdata;
      chk("rnd_mem_valid", mem_valid, emv);
      chk("rnd_m0_ready", m0_mem_ready, done && mown == 0);
      chk("rnd_m1_ready", m1_mem_ready, done && mown == 1);
      chk("rnd_grant", grant_id, mown);
      chk("rnd_busy", busy, mbusy);
      chk("rnd_terr", timeout_err, merr || fire ? (merr ? 1'b1 : 1'b0) : 1'b0);
      if (emv) begin
        chk("rnd_addr", mem_addr, raddr[mown]);
        chk("rnd_wdata", mem_wdata, rwdata[mown]);
        chk("rnd_wstrb", mem_wstrb, rwstrb[mown]);
        chk("rnd_instr", mem_instr, rinstr[mown]);
      end
      if (done && mown == 0) chk("rnd_m0_rdata", m0_mem_rdata, erd);
      if (done && mown == 1) chk("rnd_m1_rdata", m1_mem_rdata, erd);
      if (!mbusy) begin
        if (pend[0] || pend[1]) begin
          mbusy = 1;
          mcnt  = 0;
          if (pend[0] && pend[1]) mown = !mlast;
          else                    mown = pend[1];
        end
      end else if (!ov || done) begin
        mbusy = 0;
        mlast = mown;
        if (fire) merr = 1;
        if (done) pend[mown] = 0;
      end else if (!mem_ready && mcnt < 255) begin
        mcnt++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
